// File: rtl/mem_bus_mmio.sv
// CPU memory-port splitter: RAM accesses pass straight through, the MMIO window
// serves a console TX FIFO, a 64-bit cycle counter and a simulation-exit register.
module mem_bus_mmio #(
   parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FIFO_AW    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        ram_valid,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_wstrb,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        sim_done,
   output logic [7:0]  sim_code
);

   localparam int unsigned CNT_W = FIFO_AW + 1;
   localparam logic [5:0]  OFF_TXDATA = 6'h00;
   localparam logic [5:0]  OFF_STATUS = 6'h01;
   localparam logic [5:0]  OFF_CYC_LO = 6'h02;
   localparam logic [5:0]  OFF_CYC_HI = 6'h03;
   localparam logic [5:0]  OFF_EXIT   = 6'h04;

   typedef enum logic [1:0] {S_IDLE, S_STALL, S_RESP} state_e;

   state_e             state_q, state_d;
   logic               ready_q, ready_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [63:0]        cyc_q, cyc_d;
   logic [31:0]        snap_q, snap_d;
   logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               tx_valid_q, tx_valid_d;
   logic               done_q, done_d;
   logic [7:0]         code_q, code_d;
   logic [7:0]         fifo_q [FIFO_DEPTH];
   logic [7:0]         fifo_d [FIFO_DEPTH];

   logic               is_mmio, is_wr, push, pop, fifo_full, fifo_empty;
   logic [5:0]         off;
   logic               unused_c;

   assign unused_c = ^{mem_instr, mem_addr[27:8], mem_addr[1:0]};

   // Address decode and combinational RAM pass-through
   assign is_mmio   = (mem_addr[31:28] == MMIO_BASE[31:28]);
   assign is_wr     = |mem_wstrb;
   assign off       = mem_addr[7:2];
   assign ram_valid = mem_valid & ~is_mmio;
   assign ram_addr  = mem_addr;
   assign ram_wdata = mem_wdata;
   assign ram_wstrb = mem_wstrb;
   assign mem_ready = is_mmio ? ready_q : ram_ready;
   assign mem_rdata = is_mmio ? rdata_q : ram_rdata;

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign pop        = tx_valid_q & tx_ready;
   assign tx_valid   = tx_valid_q;
   assign tx_data    = fifo_q[rptr_q];
   assign sim_done   = done_q;
   assign sim_code   = code_q;

   // MMIO access FSM and register file
   always_comb begin
      state_d = state_q;
      ready_d = 1'b0;
      rdata_d = rdata_q;
      snap_d  = snap_q;
      done_d  = done_q;
      code_d  = code_q;
      cyc_d   = cyc_q + 64'(1);
      push    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (mem_valid && is_mmio) begin
               rdata_d = '0;
               ready_d = 1'b1;
               state_d = S_RESP;
               if (is_wr) begin
                  if (off == OFF_TXDATA && mem_wstrb[0]) begin
                     if (fifo_full) begin
                        ready_d = 1'b0;
                        state_d = S_STALL;
                     end else begin
                        push = 1'b1;
                     end
                  end else if (off == OFF_EXIT) begin
                     done_d = 1'b1;
                     code_d = mem_wdata[7:0];
                  end
               end else begin
                  if (off == OFF_STATUS) begin
                     rdata_d = {16'b0, 8'(count_q), 6'b0, fifo_full, fifo_empty};
                  end else if (off == OFF_CYC_LO) begin
                     rdata_d = cyc_q[31:0];
                     snap_d  = cyc_q[63:32];
                  end else if (off == OFF_CYC_HI) begin
                     rdata_d = snap_q;
                  end
               end
            end
         end
         S_STALL: begin
            if (!fifo_full) begin
               push    = 1'b1;
               ready_d = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // TX FIFO pointers and occupancy; a push only ever happens when not full
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      fifo_d = fifo_q;
      if (push) begin
         fifo_d[wptr_q] = mem_wdata[7:0];
         wptr_d         = wptr_q + FIFO_AW'(1);
      end
      if (pop) rptr_d = rptr_q + FIFO_AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      tx_valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         cyc_q      <= '0;
         snap_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         tx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         code_q     <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         rdata_q    <= rdata_d;
         cyc_q      <= cyc_d;
         snap_q     <= snap_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         tx_valid_q <= tx_valid_d;
         done_q     <= done_d;
         code_q     <= code_d;
      end
   end

   // FIFO storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_mem_bus_mmio.sv
// Directed bench for mem_bus_mmio: RAM pass-through vector table plus
// hand-written MMIO sequences (FIFO stall, counter wrap, exit, reset in stall).
module tb_mem_bus_mmio;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        ram_valid;
   logic [31:0] ram_addr, ram_wdata;
   logic [3:0]  ram_wstrb;
   logic [31:0] ram_rdata;
   logic        ram_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        sim_done;
   logic [7:0]  sim_code;

   int checks   = 0;
   int failures = 0;
   logic [7:0] rx_q[$];
   logic       tv_at_ready;
   logic [7:0] td_at_ready;

   localparam logic [31:0] A_TX   = 32'h1000_0000;
   localparam logic [31:0] A_STAT = 32'h1000_0004;
   localparam logic [31:0] A_LO   = 32'h1000_0008;
   localparam logic [31:0] A_HI   = 32'h1000_000C;
   localparam logic [31:0] A_EXIT = 32'h1000_0010;

   mem_bus_mmio dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .ram_valid(ram_valid), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata),
      .ram_ready(ram_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .sim_done(sim_done), .sim_code(sim_code)
   );

   always #5 clk = ~clk;

   // Console sink: record every accepted byte
   always @(posedge clk) begin
      if (!rst && tx_valid && tx_ready) rx_q.push_back(tx_data);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One CPU access held until mem_ready or until max_cyc edges pass
   task automatic mmio(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int max_cyc,
                       output logic [31:0] rdata, output int lat, output bit got);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      got   = 1'b0;
      lat   = 0;
      rdata = '0;
      while (!got && lat < max_cyc) begin
         @(posedge clk); #1;
         lat++;
         if (mem_ready) begin
            got = 1'b1;
            rdata = mem_rdata;
            tv_at_ready = tx_valid;
            td_at_ready = tx_data;
         end
      end
      if (got) begin
         @(posedge clk); #1;
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic acc(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rd);
      int lat;
      bit got;
      mmio(addr, wdata, wstrb, 20, rd, lat, got);
      chk({nm, "_ready"}, 64'(got), 64'd1);
      chk({nm, "_latency"}, 64'(lat), 64'd1);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        valid;
      logic        instr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] rrd;
      logic        rrdy;
      logic        e_rvalid;
      logic        e_ready;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [31:0] rd, lo;
      int lat;
      bit got;

      vecs[0] = '{32'h0000_0100, 1'b1, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0};
      vecs[1] = '{32'h0000_0100, 1'b1, 1'b1, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF};
      vecs[2] = '{32'h0FFF_FFFC, 1'b1, 1'b0, 4'h3, 32'h0000_ABCD, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
      vecs[3] = '{32'h2000_0000, 1'b1, 1'b1, 4'h0, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D};
      vecs[4] = '{32'h1000_0004, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0000_0055, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[5] = '{32'h1FFF_FFFC, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0000_0077, 1'b1, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{32'h0000_0100, 1'b0, 1'b0, 4'h0, 32'h0,         32'h0000_00A5, 1'b1, 1'b0, 1'b1, 32'h0000_00A5};

      rst = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = A_TX;
      mem_wdata = '0; mem_wstrb = '0; ram_rdata = '0; ram_ready = 1'b0; tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      #1;
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
      chk("rst_tx_valid",  64'(tx_valid),  64'd0);
      chk("rst_sim_done",  64'(sim_done),  64'd0);
      chk("rst_sim_code",  64'(sim_code),  64'd0);
      acc("rst_cyc_hi", A_HI, 32'h0, 4'h0, rd);
      chk("rst_cyc_hi_val", 64'(rd), 64'd0);

      // RAM pass-through vectors
      for (int i = 0; i < 7; i++) begin
         mem_addr  = vecs[i].addr;
         mem_valid = vecs[i].valid;
         mem_instr = vecs[i].instr;
         mem_wstrb = vecs[i].wstrb;
         mem_wdata = vecs[i].wdata;
         ram_rdata = vecs[i].rrd;
         ram_ready = vecs[i].rrdy;
         #1;
         chk($sformatf("vec%0d_ram_valid", i), 64'(ram_valid), 64'(vecs[i].e_rvalid));
         chk($sformatf("vec%0d_mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_ready));
         chk($sformatf("vec%0d_mem_rdata", i), 64'(mem_rdata), 64'(vecs[i].e_rdata));
         chk($sformatf("vec%0d_ram_addr", i),  64'(ram_addr),  64'(vecs[i].addr));
         chk($sformatf("vec%0d_ram_wdata", i), 64'(ram_wdata), 64'(vecs[i].wdata));
         chk($sformatf("vec%0d_ram_wstrb", i), 64'(ram_wstrb), 64'(vecs[i].wstrb));
         @(posedge clk); #1;
      end
      mem_valid = 1'b0; mem_instr = 1'b0; mem_wstrb = '0; ram_ready = 1'b0;
      chk("ram_no_tx", 64'(tx_valid), 64'd0);
      chk("ram_no_exit", 64'(sim_done), 64'd0);
      acc("ram_status", A_STAT, 32'h0, 4'h0, rd);
      chk("ram_status_val", 64'(rd), 64'h0000_0001);

      // Single console byte with the sink ready
      tx_ready = 1'b1;
      rx_q.delete();
      acc("tx41", A_TX, 32'h0000_0041, 4'h1, rd);
      chk("tx41_tx_valid", 64'(tv_at_ready), 64'd1);
      chk("tx41_tx_data",  64'(td_at_ready), 64'h41);
      repeat (2) @(posedge clk);
      #1;
      chk("tx41_rx_count", 64'(rx_q.size()), 64'd1);
      if (rx_q.size() > 0) chk("tx41_rx_byte", 64'(rx_q[0]), 64'h41);
      acc("tx41_status", A_STAT, 32'h0, 4'h0, rd);
      chk("tx41_status_val", 64'(rd), 64'h0000_0001);

      // Fill the FIFO, then a 17th write stalls until the sink drains one
      tx_ready = 1'b0;
      rx_q.delete();
      for (int i = 0; i < 16; i++) acc("fill", A_TX, 32'(8'h10 + i), 4'h1, rd);
      acc("full_status", A_STAT, 32'h0, 4'h0, rd);
      chk("full_status_val", 64'(rd), 64'h0000_1002);
      fork
         mmio(A_TX, 32'h0000_0020, 4'h1, 40, rd, lat, got);
         begin
            for (int k = 0; k < 5; k++) begin
               @(posedge clk); #1;
               chk("stall_head_stable", 64'(tx_data), 64'h10);
               chk("stall_no_ready", 64'(mem_ready), 64'd0);
            end
            tx_ready = 1'b1;
         end
      join
      chk("stall_got_ready", 64'(got), 64'd1);
      chk("stall_latency", 64'(lat), 64'd7);
      for (int k = 0; k < 200 && rx_q.size() < 17; k++) @(posedge clk);
      #1;
      chk("drain_count", 64'(rx_q.size()), 64'd17);
      for (int i = 0; i < 17 && i < rx_q.size(); i++)
         chk($sformatf("drain_byte%0d", i), 64'(rx_q[i]), 64'(8'h10 + i));

      // Cycle counter across the 32-bit wrap
      force dut.cyc_q = 64'h0000_0000_FFFF_FFFD;
      #1 release dut.cyc_q;
      acc("cyc_lo1", A_LO, 32'h0, 4'h0, lo);
      chk("cyc_lo1_val", 64'(lo), 64'hFFFF_FFFD);
      repeat (4) @(posedge clk);
      #1;
      acc("cyc_hi1", A_HI, 32'h0, 4'h0, rd);
      chk("cyc_hi1_val", 64'(rd), 64'd0);
      acc("cyc_lo2", A_LO, 32'h0, 4'h0, lo);
      chk("cyc_lo2_small", 64'(lo < 32'd32), 64'd1);
      acc("cyc_hi2", A_HI, 32'h0, 4'h0, rd);
      chk("cyc_hi2_val", 64'(rd), 64'd1);

      // Exit register, last write wins, cleared by reset
      acc("exit1", A_EXIT, 32'h0000_002A, 4'h1, rd);
      chk("exit1_done", 64'(sim_done), 64'd1);
      chk("exit1_code", 64'(sim_code), 64'h2A);
      acc("exit2", A_EXIT, 32'h0000_0033, 4'hF, rd);
      chk("exit2_code", 64'(sim_code), 64'h33);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("exit_rst_done", 64'(sim_done), 64'd0);
      chk("exit_rst_code", 64'(sim_code), 64'd0);

      // Reset while a write is stalled on a full FIFO
      tx_ready = 1'b0;
      rx_q.delete();
      for (int i = 0; i < 16; i++) acc("fill2", A_TX, 32'(8'h60 + i), 4'h1, rd);
      fork
         mmio(A_TX, 32'h0000_0070, 4'h1, 10, rd, lat, got);
         begin
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            mem_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("rstall_mem_ready", 64'(mem_ready), 64'd0);
            chk("rstall_tx_valid",  64'(tx_valid),  64'd0);
         end
      join
      chk("rstall_no_response", 64'(got), 64'd0);
      chk("rstall_no_bytes", 64'(rx_q.size()), 64'd0);
      acc("rstall_status", A_STAT, 32'h0, 4'h0, rd);
      chk("rstall_status_val", 64'(rd), 64'h0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
